// File: rtl/image_buffer.sv
// Two-bank ping-pong pixel store between the UART receiver and the inference engine.
// The write side fills one bank while the read side serves the other, in arrival order.
module image_buffer #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              abort,
  input  logic              weights_ready,
  input  logic              infer_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              start_inference,
  output logic [1:0]        images_pending,
  output logic              overrun
);

  typedef enum logic {W_FILL, W_WAIT} wstate_e;
  typedef enum logic {R_IDLE, R_RUN}  rstate_e;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_PIXELS - 1);

  logic [7:0] mem_q [2][NUM_PIXELS];

  wstate_e           wstate_q, wstate_d;
  rstate_e           rstate_q, rstate_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              overrun_q, overrun_d;
  logic              start_q, start_d;
  logic [1:0]        pending_q, pending_d;
  logic [7:0]        rd_data_q;
  logic              wr_en, complete, release_bank;
  logic              rd_in_range;

  assign rd_in_range = (32'(rd_addr) < NUM_PIXELS);

  always_comb begin
    rstate_d     = rstate_q;
    rd_bank_d    = rd_bank_q;
    start_d      = 1'b0;
    release_bank = 1'b0;
    wstate_d     = wstate_q;
    wr_ptr_d     = wr_ptr_q;
    wr_bank_d    = wr_bank_q;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;
    complete     = 1'b0;

    unique case (rstate_q)
      R_IDLE: begin
        if (full_q[rd_bank_q] && weights_ready) begin
          start_d  = 1'b1;
          rstate_d = R_RUN;
        end
      end
      R_RUN: begin
        if (infer_done) begin
          release_bank = 1'b1;
          rd_bank_d    = ~rd_bank_q;
          rstate_d     = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    unique case (wstate_q)
      W_FILL: begin
        if (abort) begin
          wr_ptr_d  = '0;
          overrun_d = 1'b0;
        end else if (rx_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            complete  = 1'b1;
            wr_ptr_d  = '0;
            wr_bank_d = ~wr_bank_q;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      W_WAIT: begin
        if (abort) begin
          wr_ptr_d  = '0;
          overrun_d = 1'b0;
        end else if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (!full_q[wr_bank_q]) begin
          wstate_d = W_FILL;
          wr_ptr_d = '0;
        end
      end
      default: wstate_d = W_FILL;
    endcase

    // Completion and release always target different banks, so both apply; the
    // wait decision looks at the net flags so a same-cycle release keeps filling.
    full_d = full_q;
    if (complete)     full_d[wr_bank_q] = 1'b1;
    if (release_bank) full_d[rd_bank_q] = 1'b0;
    if (complete && full_d[wr_bank_d]) wstate_d = W_WAIT;

    pending_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q  <= W_FILL;
      rstate_q  <= R_IDLE;
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      overrun_q <= 1'b0;
      start_q   <= 1'b0;
      pending_q <= '0;
      rd_data_q <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      start_q   <= start_d;
      pending_q <= pending_d;
      rd_data_q <= rd_in_range ? mem_q[rd_bank_q][rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_bank_q][wr_ptr_q] <= rx_data;
  end

  assign rd_data         = rd_data_q;
  assign start_inference = start_q;
  assign images_pending  = pending_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_image_buffer.sv
// Self-checking bench for image_buffer: address table on a loaded image plus
// hand-written multi-image sequences, with rd_data checked through a scoreboard queue.
module tb_image_buffer;

  localparam int NP = 784;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          abort;
  logic          weights_ready;
  logic          infer_done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          start_inference;
  logic [1:0]    images_pending;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int s0;
  int sb[$];

  typedef struct {
    int addr;
    int exp;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  image_buffer #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .abort          (abort),
    .weights_ready  (weights_ready),
    .infer_done     (infer_done),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .start_inference(start_inference),
    .images_pending (images_pending),
    .overrun        (overrun)
  );

  always @(negedge clk) if (start_inference === 1'b1) start_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pat(input int kind, input int i);
    case (kind)
      0:       return i % 256;
      1:       return (i * 3 + 7) % 256;
      2:       return (i ^ 90) % 256;
      3:       return (i * 7 + 1) % 256;
      4:       return 255 - (i % 256);
      default: return (i * 11) % 256;
    endcase
  endfunction

  task automatic send_byte(input int b);
    rx_data  = 8'(b);
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_image(input int kind, input int n);
    for (int i = 0; i < n; i++) send_byte(pat(kind, i));
  endtask

  task automatic rd_chk(input string nm, input int addr, input int exp);
    rd_addr = AW'(addr);
    sb.push_back(exp);
    step();
    chk(nm, rd_data, sb.pop_front());
  endtask

  task automatic rd_image(input string nm, input int kind);
    int addrs[6] = '{0, 1, 299, 300, 500, 783};
    for (int k = 0; k < 6; k++) rd_chk(nm, addrs[k], pat(kind, addrs[k]));
  endtask

  task automatic pulse_done();
    infer_done = 1'b1;
    step();
    infer_done = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0, 0};
    tbl[1] = '{5, 5};
    tbl[2] = '{255, 255};
    tbl[3] = '{256, 0};
    tbl[4] = '{300, 44};
    tbl[5] = '{783, 15};
    tbl[6] = '{784, 0};
    tbl[7] = '{1023, 0};

    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; abort = 1'b0;
    weights_ready = 1'b1; infer_done = 1'b0; rd_addr = '0;
    repeat (2) step();
    chk("reset_start", start_inference, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_pending", images_pending, 0);
    chk("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    step();

    // Image A (index mod 256) into bank 0; start one cycle after pending rises.
    send_image(0, NP);
    chk("A_pending", images_pending, 1);
    chk("A_start_early", start_inference, 0);
    step();
    chk("A_start", start_inference, 1);
    step();
    chk("A_start_width", start_inference, 0);
    chk("A_start_cnt", start_cnt, 1);
    for (int v = 0; v < 8; v++) rd_chk("A_tbl", tbl[v].addr, tbl[v].exp);

    // Image B fills bank 1, then the third image is dropped.
    send_image(1, NP);
    chk("B_pending2", images_pending, 2);
    chk("B_no_overrun", overrun, 0);
    send_image(4, 10);
    chk("drop_overrun", overrun, 1);
    chk("drop_pending", images_pending, 2);
    chk("drop_no_start", start_cnt, 1);
    pulse_done();
    chk("relA_pending", images_pending, 1);
    step();
    chk("B_start", start_inference, 1);
    rd_image("B_data", 1);

    // Image C must land in bank 0 from address 0 with none of the dropped bytes.
    send_image(2, NP);
    chk("C_pending2", images_pending, 2);
    pulse_done();
    step();
    chk("C_start", start_inference, 1);
    rd_image("C_data", 2);
    pulse_done();
    chk("relC_pending", images_pending, 0);
    chk("overrun_sticky", overrun, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_clr_overrun", overrun, 0);

    // Partial image, abort colliding with a byte, then a full image.
    s0 = start_cnt;
    send_image(4, 300);
    chk("partial_no_start", start_cnt - s0, 0);
    rx_data = 8'hAA; rx_valid = 1'b1; abort = 1'b1;
    step();
    rx_valid = 1'b0; abort = 1'b0;
    send_image(3, NP);
    step();
    step();
    chk("D_one_start", start_cnt - s0, 1);
    chk("D_overrun", overrun, 0);
    rd_image("D_data", 3);
    pulse_done();

    // Weights not ready: hold full banks, keep filling.
    weights_ready = 1'b0;
    s0 = start_cnt;
    send_image(5, NP);
    repeat (3) step();
    chk("E_held_pending", images_pending, 1);
    chk("E_held_start", start_cnt - s0, 0);
    send_image(1, NP);
    chk("F_pending2", images_pending, 2);
    chk("F_held_start", start_cnt - s0, 0);
    weights_ready = 1'b1;
    step();
    chk("E_start", start_inference, 1);
    rd_image("E_data", 5);
    send_byte(0);
    chk("F_overrun", overrun, 1);

    // Reset mid-inference with both banks full.
    rst_n = 1'b0;
    step();
    chk("rst2_start", start_inference, 0);
    chk("rst2_rd_data", rd_data, 0);
    chk("rst2_pending", images_pending, 0);
    chk("rst2_overrun", overrun, 0);
    rst_n = 1'b1;
    s0 = start_cnt;
    pulse_done();
    repeat (3) step();
    chk("stray_done_start", start_cnt - s0, 0);
    chk("stray_done_pending", images_pending, 0);
    send_image(0, NP);
    step();
    chk("post_rst_start", start_inference, 1);
    rd_chk("post_rst_data", 5, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
